// File: rtl/program_load_pkg.sv
// program_load_pkg
//   Shared types and constants for the program-load sink.
//   - load_state_t   : load FSM states (IDLE, LOAD, DONE)
//   - WORD_BYTES     : bytes per program RAM word
//   - WORD_SHIFT     : log2(WORD_BYTES), byte address -> word address shift
//   - LOAD_BEATS     : number of RAM words in a full program image
//   - checksum_fold  : XOR-fold of the sixteen 32-bit lanes of a strobe-masked beat
package program_load_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  localparam int WORD_BYTES = 64;
  localparam int WORD_SHIFT = 6;
  localparam int LOAD_BYTES = 2048;
  localparam int LOAD_BEATS = LOAD_BYTES / WORD_BYTES;

  // Bytes whose strobe is low contribute zero, so the checksum reflects
  // exactly what was written into the RAM.
  function automatic logic [31:0] checksum_fold(input logic [511:0] data,
                                                input logic [63:0]  strb);
    logic [511:0] masked;
    logic [31:0]  acc;
    for (int i = 0; i < 64; i++) begin
      masked[i*8 +: 8] = strb[i] ? data[i*8 +: 8] : 8'h00;
    end
    acc = '0;
    for (int l = 0; l < 16; l++) begin
      acc = acc ^ masked[l*32 +: 32];
    end
    return acc;
  endfunction

endpackage

// File: rtl/program_load_addr_fifo.sv
// program_load_addr_fifo
//   Small synchronous FIFO holding pending RAM word addresses between the
//   address and data channels. Pointers wrap modulo DEPTH (power of two, >= 2).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   flush       : empties the FIFO; wins over push/pop
//   push        : write push_data (ignored when full)
//   push_data   : entry to store
//   pop         : drop the head entry (ignored when empty)
//   pop_data    : head entry (valid while !empty)
//   full, empty : occupancy flags
module program_load_addr_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/program_load_sink.sv
// program_load_sink
//   Responder end of the program-load write interface. Pairs independent
//   address (aw) and data (w) streams in order and drives a registered,
//   byte-enabled write port into the 512-bit program RAM.
// Ports:
//   axi4_mm_clk, axi4_mm_rst_n      : clock, synchronous active-low reset
//   program_load_en                 : load window enable
//   program_load_aw_*               : address stream (valid/ready/byte addr)
//   program_load_w_*                : data stream (valid/ready/data/strb)
//   mem_wr_en/addr/data/be          : RAM write port, one cycle after a W handshake
//   load_busy / load_done           : FSM in LOAD / DONE
//   load_err_misaligned             : sticky, an address had nonzero low bits
//   beat_count                      : W beats accepted in the current load
//   load_checksum                   : only when PROGRAM_LOAD_CHECKSUM_EN is defined
//
// Handshake rules: a transfer happens on a rising clock edge where valid and
// ready are both high. ready depends only on registered state (FSM and FIFO
// occupancy), never on valid, so there is no combinational path from valid to
// ready. aw_ready drops while the address FIFO is full, even if a pop happens
// in the same cycle; w_ready needs an address already in the FIFO at the start
// of the cycle, so a W beat is always accepted at least a cycle after its AW.
module program_load_sink
  import program_load_pkg::*;
#(
  parameter int ADDR_WIDTH    = 15,
  parameter int DATA_WIDTH    = 512,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int AW_FIFO_DEPTH = 4,
  parameter int LOAD_BYTES    = 2048
) (
  input  logic                         axi4_mm_clk,
  input  logic                         axi4_mm_rst_n,
  input  logic                         program_load_en,
  input  logic                         program_load_aw_valid,
  output logic                         program_load_aw_ready,
  input  logic [ADDR_WIDTH-1:0]        program_load_aw_payload_addr,
  input  logic                         program_load_w_valid,
  output logic                         program_load_w_ready,
  input  logic [DATA_WIDTH-1:0]        program_load_w_payload_data,
  input  logic [STRB_WIDTH-1:0]        program_load_w_payload_strb,
  output logic                         mem_wr_en,
  output logic [ADDR_WIDTH-WORD_SHIFT-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0]        mem_wr_data,
  output logic [STRB_WIDTH-1:0]        mem_wr_be,
  output logic                         load_busy,
  output logic                         load_done,
  output logic                         load_err_misaligned,
  output logic [ADDR_WIDTH-6:0]        beat_count
`ifdef PROGRAM_LOAD_CHECKSUM_EN
  ,
  output logic [31:0]                  load_checksum
`endif
);

  localparam int WADDR_W     = ADDR_WIDTH - WORD_SHIFT;
  localparam int CNT_W       = ADDR_WIDTH - 5;
  localparam int BEAT_TARGET = LOAD_BYTES / (DATA_WIDTH / 8);

  load_state_t        state;
  logic               aw_hs;
  logic               w_hs;
  logic               fifo_flush;
  logic               fifo_full;
  logic               fifo_empty;
  logic [WADDR_W-1:0] fifo_head;
  logic               load_start;

  assign program_load_aw_ready = (state == LOAD) && !fifo_full;
  assign program_load_w_ready  = (state == LOAD) && !fifo_empty;
  assign aw_hs = program_load_aw_valid && program_load_aw_ready;
  assign w_hs  = program_load_w_valid && program_load_w_ready;

  // Outside LOAD the FIFO is held empty: this drops addresses left over on
  // abort and any that arrived together with the final beat.
  assign fifo_flush = (state != LOAD);
  assign load_start = (state == IDLE) && program_load_en;

  assign load_busy = (state == LOAD);
  assign load_done = (state == DONE);

  program_load_addr_fifo #(
    .WIDTH (WADDR_W),
    .DEPTH (AW_FIFO_DEPTH)
  ) u_addr_fifo (
    .clk       (axi4_mm_clk),
    .rst_n     (axi4_mm_rst_n),
    .flush     (fifo_flush),
    .push      (aw_hs),
    .push_data (program_load_aw_payload_addr[ADDR_WIDTH-1:WORD_SHIFT]),
    .pop       (w_hs),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge axi4_mm_clk) begin
    if (!axi4_mm_rst_n) begin
      state               <= IDLE;
      beat_count          <= '0;
      load_err_misaligned <= 1'b0;
      mem_wr_en           <= 1'b0;
      mem_wr_addr         <= '0;
      mem_wr_data         <= '0;
      mem_wr_be           <= '0;
    end else begin
      // A beat accepted in the abort cycle is still written; the readies are
      // low from the following cycle on, so nothing issues after that.
      mem_wr_en <= w_hs;
      if (w_hs) begin
        mem_wr_addr <= fifo_head;
        mem_wr_data <= program_load_w_payload_data;
        mem_wr_be   <= program_load_w_payload_strb;
      end

      case (state)
        IDLE: begin
          if (program_load_en) begin
            state               <= LOAD;
            beat_count          <= '0;
            load_err_misaligned <= 1'b0;
          end
        end
        LOAD: begin
          if (aw_hs && (program_load_aw_payload_addr[WORD_SHIFT-1:0] != '0)) begin
            load_err_misaligned <= 1'b1;
          end
          if (w_hs) begin
            beat_count <= beat_count + CNT_W'(1);
          end
          // Completing the image wins over a simultaneous enable drop.
          if (w_hs && (beat_count == CNT_W'(BEAT_TARGET - 1))) begin
            state <= DONE;
          end else if (!program_load_en) begin
            state <= IDLE;
          end
        end
        DONE: begin
          if (!program_load_en) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PROGRAM_LOAD_CHECKSUM_EN
  always_ff @(posedge axi4_mm_clk) begin
    if (!axi4_mm_rst_n || load_start) begin
      load_checksum <= '0;
    end else if (w_hs) begin
      load_checksum <= load_checksum +
                       checksum_fold(program_load_w_payload_data, program_load_w_payload_strb);
    end
  end
`endif

endmodule

// File: tb/tb_program_load_sink.sv
// tb_program_load_sink
//   Directed bench for program_load_sink. Inputs change 1 time unit after the
//   rising edge; the write port is sampled on the falling edge and compared
//   against an expected queue of {cycle, word, be, data} entries built from
//   the addresses and beats the bench itself presented.
module tb_program_load_sink;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          aw_valid = 1'b0;
  logic [14:0]   aw_addr = '0;
  logic          w_valid = 1'b0;
  logic [511:0]  w_data = '0;
  logic [63:0]   w_strb = '0;

  logic          aw_ready;
  logic          w_ready;
  logic          mem_wr_en;
  logic [8:0]    mem_wr_addr;
  logic [511:0]  mem_wr_data;
  logic [63:0]   mem_wr_be;
  logic          busy;
  logic          done;
  logic          err;
  logic [9:0]    beat_count;
`ifdef PROGRAM_LOAD_CHECKSUM_EN
  logic [31:0]   load_checksum;
`endif

  program_load_sink dut (
    .axi4_mm_clk                  (clk),
    .axi4_mm_rst_n                (rst_n),
    .program_load_en              (en),
    .program_load_aw_valid        (aw_valid),
    .program_load_aw_ready        (aw_ready),
    .program_load_aw_payload_addr (aw_addr),
    .program_load_w_valid         (w_valid),
    .program_load_w_ready         (w_ready),
    .program_load_w_payload_data  (w_data),
    .program_load_w_payload_strb  (w_strb),
    .mem_wr_en                    (mem_wr_en),
    .mem_wr_addr                  (mem_wr_addr),
    .mem_wr_data                  (mem_wr_data),
    .mem_wr_be                    (mem_wr_be),
    .load_busy                    (busy),
    .load_done                    (done),
    .load_err_misaligned          (err),
    .beat_count                   (beat_count)
`ifdef PROGRAM_LOAD_CHECKSUM_EN
    ,
    .load_checksum                (load_checksum)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bench state ----------------
  int            n_vec = 0;
  int            n_err = 0;
  int            wr_pulses = 0;
  int            aw_idx, aw_lim, w_idx, w_lim;
  int            used;
  int            data_mode = 0;
  logic [14:0]   aw_base = '0;
  logic [63:0]   w_strb_g = '1;
  logic [8:0]    tb_aw_q[$];
  logic [600:0]  exp_q[$];
  logic [600:0]  mon_e;

  task automatic check(input string tag, input logic [607:0] obs, input logic [607:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] beat_data(input int idx);
    logic [511:0] d;
    for (int l = 0; l < 16; l++) begin
      d[l*32 +: 32] = (data_mode == 1) ? 32'h0000_0001 : {8'(idx), 8'(l), 16'hC3A5};
    end
    return d;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      wr_pulses++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 1'b1, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_port", {16'(cyc), mem_wr_addr, mem_wr_be, mem_wr_data}, mon_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One clock of traffic: present the next AW / W if the limits allow.
  task automatic step();
    logic aw_hs, w_hs;
    aw_valid = (aw_idx < aw_lim);
    aw_addr  = aw_base + 15'(aw_idx * 64);
    w_valid  = (w_idx < w_lim);
    w_data   = beat_data(w_idx);
    w_strb   = w_strb_g;
    aw_hs = aw_valid && aw_ready;
    w_hs  = w_valid && w_ready;
    // Pop before push: a W beat may only pair with an address accepted earlier.
    if (w_hs) begin
      if (tb_aw_q.size() == 0) check("w_ready_without_aw", 1'b1, 1'b0);
      else exp_q.push_back({16'(cyc + 1), tb_aw_q.pop_front(), w_strb, w_data});
    end
    if (aw_hs) tb_aw_q.push_back(aw_addr[14:6]);
    @(posedge clk);
    #1;
    if (aw_hs) aw_idx++;
    if (w_hs)  w_idx++;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input int max_cycles, output int n);
    n = 0;
    while ((aw_idx < aw_lim || w_idx < w_lim) && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, "_complete"}, (aw_idx >= aw_lim) && (w_idx >= w_lim), 1'b1);
  endtask

  task automatic new_load(input logic [14:0] base, input int n_aw, input int n_w);
    tb_aw_q.delete();
    wr_pulses = 0;
    aw_idx = 0;
    w_idx = 0;
    aw_base = base;
    aw_lim = n_aw;
    w_lim = n_w;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    aw_idx = 0; aw_lim = 0; w_idx = 0; w_lim = 0;
    rst_n = 1'b0;
    wait_cycles(3);
    check("rst_outputs", {aw_ready, w_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be,
                          busy, done, err, beat_count}, '0);
    rst_n = 1'b1;
    wait_cycles(2);
    check("idle_no_enable", {busy, done, aw_ready, w_ready}, 4'b0000);

    // Back-to-back full load
    new_load(15'h000, 32, 32);
    en = 1'b1;
    wait_cycles(1);
    check("t1_entry", {busy, done, beat_count}, {1'b1, 1'b0, 10'd0});
    run_xfer("t1", 100, used);
    check("t1_cycles", used, 33);
    check("t1_done", {busy, done, aw_ready, w_ready, beat_count}, {4'b0100, 10'd32});
    aw_lim = 34; w_lim = 34;
    repeat (2) step();
    check("t1_done_ignores", {done, beat_count, 8'(aw_idx), 8'(w_idx)},
          {1'b1, 10'd32, 8'd32, 8'd32});
    check("t1_pulses", wr_pulses, 32);
    en = 1'b0;
    wait_cycles(1);
    check("t1_idle_holds", {busy, done, beat_count}, {2'b00, 10'd32});

    // Address stream runs ahead of data
    new_load(15'h000, 6, 0);
    en = 1'b1;
    wait_cycles(1);
    check("t2_entry_clears", beat_count, 10'd0);
    repeat (8) step();
    check("t2_aw_accepted", aw_idx, 4);
    check("t2_aw_ready_full", aw_ready, 1'b0);
    w_lim = 6;
    run_xfer("t2", 30, used);
    wait_cycles(1);
    check("t2_pulses", wr_pulses, 6);
    check("t2_beats", beat_count, 10'd6);
    en = 1'b0;
    wait_cycles(1);

    // Data offered before any address
    new_load(15'h080, 0, 1);
    en = 1'b1;
    wait_cycles(1);
    repeat (3) step();
    check("t3_w_ready_no_aw", {w_ready, 8'(w_idx)}, 9'd0);
    aw_lim = 1;
    step();
    check("t3_w_ready_t1", w_ready, 1'b1);
    step();
    check("t3_wr_t2", {mem_wr_en, mem_wr_addr}, {1'b1, 9'd2});
    en = 1'b0;
    wait_cycles(1);

    // Abort after 10 beats with two addresses still pending
    new_load(15'h000, 12, 10);
    en = 1'b1;
    wait_cycles(1);
    run_xfer("t4", 40, used);
    en = 1'b0;
    step();
    w_lim = 12;
    repeat (3) step();
    check("t4_pulses", wr_pulses, 10);
    check("t4_state", {busy, done, aw_ready, w_ready}, 4'b0000);
    check("t4_no_late_beats", w_idx, 10);
    tb_aw_q.delete();
    en = 1'b1;
    wait_cycles(1);
    check("t4_restart", {busy, beat_count, w_ready}, {1'b1, 10'd0, 1'b0});
    en = 1'b0;
    wait_cycles(1);

    // Misaligned address and zero-strobe beat
    new_load(15'h041, 1, 1);
    w_strb_g = 64'h0000_0000_0000_000F;
    en = 1'b1;
    wait_cycles(1);
    check("t5_err_clear", err, 1'b0);
    run_xfer("t5a", 10, used);
    check("t5_err_set", err, 1'b1);
    check("t5_wr_word1", {mem_wr_en, mem_wr_addr, mem_wr_be}, {1'b1, 9'd1, 64'hF});
    w_strb_g = '0;
    aw_lim = 2; w_lim = 2;
    run_xfer("t5b", 10, used);
    check("t5_zero_be", {mem_wr_en, mem_wr_addr, mem_wr_be}, {1'b1, 9'd2, 64'd0});
    check("t5_beats", beat_count, 10'd2);
`ifdef PROGRAM_LOAD_CHECKSUM_EN
    check("t5_checksum", load_checksum, 32'h0000_C3A5);
`endif
    en = 1'b0;
    wait_cycles(1);

    // Reset in the middle of a load
    new_load(15'h000, 7, 5);
    w_strb_g = '1;
    en = 1'b1;
    wait_cycles(1);
    check("t6_err_cleared", err, 1'b0);
    run_xfer("t6", 30, used);
    wait_cycles(1);
    check("t6_pulses_before", wr_pulses, 5);
    rst_n = 1'b0;
    wait_cycles(1);
    check("t6_rst_outputs", {aw_ready, w_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be,
                             busy, done, err, beat_count}, '0);
    rst_n = 1'b1;
    tb_aw_q.delete();
    w_lim = 7;
    repeat (4) step();
    check("t6_no_write_after_rst", {8'(wr_pulses), w_ready, 8'(w_idx)}, {8'd5, 1'b0, 8'd5});
    en = 1'b0;
    wait_cycles(1);

    // Full load of constant lanes
    new_load(15'h000, 32, 32);
    data_mode = 1;
    en = 1'b1;
    wait_cycles(1);
    run_xfer("t7", 100, used);
    check("t7_done", {done, beat_count}, {1'b1, 10'd32});
`ifdef PROGRAM_LOAD_CHECKSUM_EN
    check("t7_checksum", load_checksum, 32'h0);
`endif
    en = 1'b0;
    wait_cycles(2);
    check("t7_pulses", wr_pulses, 32);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net: never let the run hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1);
  end

endmodule

// File: doc/program_load_sink.md
Name: program_load_sink

Overview:
- Responder end of the program-load write interface.
- Accepts independent address (aw) and data (w) valid/ready streams and pairs them in order.
- Drives a registered, byte-enabled write port into the core's 512-bit on-chip program RAM.
- Sits inside the core wrapper; active only while program_load_en is high and the core is held in reset.

Parameters:
- ADDR_WIDTH, 15, byte address width of aw_payload_addr
- DATA_WIDTH, 512, w data width; one beat is one RAM word
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
- AW_FIFO_DEPTH, 4, pending-address FIFO entries (power of two)
- LOAD_BYTES, 2048, image size; LOAD_BEATS = LOAD_BYTES/(DATA_WIDTH/8) = 32

Ports:
- axi4_mm_clk  in  1  clock
- axi4_mm_rst_n  in  1  reset; synchronous, active-low
- program_load_en  in  1  load window enable
- program_load_aw_valid  in  1  address valid
- program_load_aw_ready  out  1  address ready
- program_load_aw_payload_addr  in  ADDR_WIDTH  byte address
- program_load_w_valid  in  1  data valid
- program_load_w_ready  out  1  data ready
- program_load_w_payload_data  in  DATA_WIDTH  data beat
- program_load_w_payload_strb  in  STRB_WIDTH  byte strobes
- mem_wr_en  out  1  RAM write strobe
- mem_wr_addr  out  ADDR_WIDTH-6  RAM word address
- mem_wr_data  out  DATA_WIDTH  RAM write data
- mem_wr_be  out  STRB_WIDTH  RAM byte enables
- load_busy  out  1  state LOAD
- load_done  out  1  state DONE
- load_err_misaligned  out  1  sticky: an address had nonzero bits [5:0]
- beat_count  out  ADDR_WIDTH-5  accepted W beats

Behaviour:
- **Reset** (axi4_mm_rst_n=0 at posedge): state IDLE, FIFO empty, all outputs 0. Reset mid-load discards pending addresses; no write follows.
- **FSM**
  - IDLE → LOAD when program_load_en=1; clears beat_count and load_err_misaligned on entry.
  - LOAD → DONE on the W handshake that makes beat_count == LOAD_BEATS.
  - LOAD → IDLE if program_load_en=0 (abort): FIFO flushed, load_done stays 0.
  - DONE → IDLE when program_load_en=0. beat_count holds in DONE and clears only on the next IDLE → LOAD.
- **aw channel**
  - aw_ready = (state==LOAD) && FIFO count < AW_FIFO_DEPTH. When full, aw_ready is 0 even if a pop occurs that cycle (no pass-through).
  - On handshake, push addr[ADDR_WIDTH-1:6]. If addr[5:0] != 0, set load_err_misaligned; the address is still truncated and used.
- **w channel**
  - w_ready = (state==LOAD) && FIFO non-empty at the start of the cycle. No same-cycle AW bypass, so W is accepted at least 1 cycle after its AW.
  - On handshake, pop the FIFO and increment beat_count.
  - Next cycle: mem_wr_en=1 with mem_wr_addr=popped word, mem_wr_data=data, mem_wr_be=strb. Latency is exactly 1 cycle.
  - Sustained throughput is 1 beat/cycle.
  - An all-zero strb still produces mem_wr_en with be=0 and is counted.
- **Write-port idle state**: mem_wr_en is 0 when no write is issued; addr/data/be hold their last values.
- **Abort timing**: a write registered in the abort cycle still issues. Nothing issues after that.
- **DONE state**: both readies are 0 and extra beats/addresses are ignored. Addresses left in the FIFO at DONE are dropped.
- **FIFO**: pointers wrap modulo AW_FIFO_DEPTH; count width is log2(depth)+1.

Optional Feature:
- Macro: PROGRAM_LOAD_CHECKSUM_EN.
- With the macro: extra output load_checksum [31:0].
  - Cleared on IDLE → LOAD.
  - On each W handshake, adds the XOR-fold of the 16 32-bit lanes of (data masked by strb), modulo 2^32.
  - Updates in the cycle after the handshake; valid while load_done=1.
- Without the macro: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package program_load_pkg holds:
  - state enum {IDLE, LOAD, DONE};
  - localparams WORD_BYTES=64, WORD_SHIFT=6, LOAD_BEATS;
  - checksum fold function.
- One sub-module, program_load_addr_fifo: synchronous FIFO with push/pop/flush/full/empty/count, depth AW_FIFO_DEPTH.

Test Plan:
- **Back-to-back load**: en=1; AW 0x000..0x7C0 and W valid every cycle → 32 writes, words 0..31 in order, one per cycle after the first. load_done=1 after beat 32; beat_count=32.
- **AW runs ahead**: 6 AWs with w_valid=0 → aw_ready low after 4 accepted. Then 6 W beats → mem_wr_addr 0..5 in order.
- **W before AW**: w_valid=1 with no AW → w_ready=0. AW 0x080 at cycle t → w_ready=1 at t+1, write to word 2 at t+2.
- **Abort**: en dropped after 10 W handshakes → exactly 10 mem_wr_en pulses, load_busy=0, load_done=0. Re-raising en restarts with beat_count=0.
- **Misaligned address and zero strobe**: AW 0x041 → load_err_misaligned=1, write to word 1. A beat with strb=0 → mem_wr_en=1, mem_wr_be=0, counted.
- **Reset mid-load / checksum**: axi4_mm_rst_n=0 after 5 beats → all outputs 0 next edge, no further writes. With PROGRAM_LOAD_CHECKSUM_EN, 32 beats of constant data 0x00000001 per lane, strb all ones → load_checksum=0 (16-lane fold of 1 is 0).
